// File: rtl/regfile_writeback.sv
// Write-back front end: merges ALU and load results into a small in-order queue
// and drains it onto the register file's single write port, one entry per cycle.
module regfile_writeback #(
    parameter int WORD  = 32,   // CPU word length
    parameter int ADDR  = 5,    // log2 of the word length, matches register file addressing
    parameter int DEPTH = 4     // power of two, at least 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [ADDR-1:0]           alu_addr,
    input  logic [WORD-1:0]           alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [ADDR-1:0]           mem_addr,
    input  logic [WORD-1:0]           mem_data,
    output logic                      rf_en,
    output logic [ADDR-1:0]           rf_addr,
    output logic [WORD-1:0]           rf_data,
    input  logic [ADDR-1:0]           query_addr,
    output logic                      query_hit,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR-1:0] addr;
        logic [WORD-1:0] data;
    } entry_t;

    entry_t          r_queue [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_last_mem;

    logic            w_space;
    logic            w_alu_grant;
    logic            w_mem_grant;
    logic            w_alu_push;
    logic            w_mem_push;
    logic            w_push;
    logic            w_pop;
    entry_t          w_push_entry;
    entry_t          w_head_entry;
    logic            w_hit;

    // A producer's grant looks only at the other producer's valid, so ready never
    // depends on its own valid; at most one transfer can happen per cycle.
    always_comb begin
        w_space      = (r_count < CW'(DEPTH));
        w_alu_grant  = w_space && (!mem_valid || r_last_mem);
        w_mem_grant  = w_space && (!alu_valid || !r_last_mem);
        w_alu_push   = alu_valid && w_alu_grant;
        w_mem_push   = mem_valid && w_mem_grant;
        w_push       = w_alu_push || w_mem_push;
        w_push_entry = w_mem_push ? entry_t'{mem_addr, mem_data} : entry_t'{alu_addr, alu_data};
        w_pop        = (r_count != '0);
        w_head_entry = r_queue[r_head];
    end

    // Reset gates only the outputs so the readies read 0 while reset is held.
    assign alu_ready = rst && w_alu_grant;
    assign mem_ready = rst && w_mem_grant;
    assign rf_en     = w_pop;
    assign rf_addr   = w_pop ? w_head_entry.addr : '0;
    assign rf_data   = w_pop ? w_head_entry.data : '0;
    assign count     = r_count;

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(PW'(i) - r_head) < r_count) && (r_queue[i].addr == query_addr)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign query_hit = w_hit;

    // NOTE: queue storage has no reset; occupancy is defined by r_count alone, which keeps the RAM reset-free.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_queue[r_tail] <= w_push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_last_mem <= 1'b1;
        end else begin
            if (w_push) begin
                r_tail     <= r_tail + PW'(1);
                r_last_mem <= w_mem_push;
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a scoreboard queue models the write queue,
// the arbiter and the register file, and every cycle is compared against it.
module tb_regfile_writeback;

    localparam int WORD  = 32;
    localparam int ADDR  = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR-1:0]   alu_addr;
    logic [WORD-1:0]   alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR-1:0]   mem_addr;
    logic [WORD-1:0]   mem_data;
    logic              rf_en;
    logic [ADDR-1:0]   rf_addr;
    logic [WORD-1:0]   rf_data;
    logic [ADDR-1:0]   query_addr;
    logic              query_hit;
    logic [CW-1:0]     count;

    always #5 clk = ~clk;

    regfile_writeback #(.WORD(WORD), .ADDR(ADDR), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .rf_en      (rf_en),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .query_addr (query_addr),
        .query_hit  (query_hit),
        .count      (count)
    );

    typedef struct {
        logic [ADDR-1:0] addr;
        logic [WORD-1:0] data;
    } item_t;

    item_t            sb[$];
    bit               m_last_mem;
    logic [WORD-1:0]  rf_model [32];
    int               r4_writes;
    int               n_assert = 0;
    int               n_fail   = 0;
    logic [ADDR-1:0]  seq_addr = '0;
    bit               grant_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; returns the model's grants.
    task automatic cycle(output bit ga, output bit gm);
        bit              hit;
        logic            seen_en;
        logic [ADDR-1:0] seen_addr;
        logic [WORD-1:0] seen_data;
        #1;
        ga = 1'b0;
        gm = 1'b0;
        if (sb.size() < DEPTH) begin
            if (alu_valid && mem_valid) begin
                if (m_last_mem) ga = 1'b1;
                else            gm = 1'b1;
            end else if (alu_valid) begin
                ga = 1'b1;
            end else if (mem_valid) begin
                gm = 1'b1;
            end
        end
        if (alu_valid) check("alu_ready", alu_ready, ga);
        if (mem_valid) check("mem_ready", mem_ready, gm);
        check("count", count, sb.size());
        check("rf_en", rf_en, sb.size() != 0);
        if (sb.size() != 0) begin
            check("rf_addr", rf_addr, sb[0].addr);
            check("rf_data", rf_data, sb[0].data);
        end
        hit = 1'b0;
        foreach (sb[k]) if (sb[k].addr == query_addr) hit = 1'b1;
        check("query_hit", query_hit, hit);
        seen_en   = rf_en;
        seen_addr = rf_addr;
        seen_data = rf_data;
        @(posedge clk);
        if (seen_en === 1'b1) begin
            rf_model[seen_addr] = seen_data;
            if (seen_addr == 5'd4) r4_writes++;
        end
        if (sb.size() != 0) void'(sb.pop_front());
        if (ga) begin
            sb.push_back('{alu_addr, alu_data});
            m_last_mem = 1'b0;
            grant_log.push_back(1'b0);
        end
        if (gm) begin
            sb.push_back('{mem_addr, mem_data});
            m_last_mem = 1'b1;
            grant_log.push_back(1'b1);
        end
        @(negedge clk);
    endtask

    function automatic logic [ADDR-1:0] next_addr();
        seq_addr = (seq_addr == 5'd31) ? 5'd1 : seq_addr + 5'd1;
        return seq_addr;
    endfunction

    // Offers from the enabled producers for n cycles; a producer holds its item until accepted.
    task automatic run(input int n, input bit a_on, input bit m_on);
        bit ga, gm, a_pend, m_pend;
        a_pend = 1'b0;
        m_pend = 1'b0;
        alu_addr = next_addr(); alu_data = $urandom;
        mem_addr = next_addr(); mem_data = $urandom;
        for (int c = 0; c < n + 8; c++) begin
            if (c >= n && !a_pend && !m_pend) break;
            alu_valid = (c < n && a_on) || a_pend;
            mem_valid = (c < n && m_on) || m_pend;
            cycle(ga, gm);
            a_pend = alu_valid && !ga;
            m_pend = mem_valid && !gm;
            if (ga) begin alu_addr = next_addr(); alu_data = $urandom; end
            if (gm) begin mem_addr = next_addr(); mem_data = $urandom; end
        end
        check("run_drained_handshakes", {a_pend, m_pend}, 2'b00);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        bit ga, gm;
        rst = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1;
        alu_addr = 5'd1; alu_data = '0; mem_addr = 5'd2; mem_data = '0;
        query_addr = '0;
        m_last_mem = 1'b1;
        r4_writes = 0;
        foreach (rf_model[k]) rf_model[k] = '0;
        #2 rst = 1'b0;
        #10;
        check("rst_count", count, 0);
        check("rst_rf_en", rf_en, 0);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_query_hit", query_hit, 0);
        check("rst_rf_addr", rf_addr, 0);
        check("rst_rf_data", rf_data, 0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Single write: accepted, written the next edge, then idle.
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hDEADBEEF;
        cycle(ga, gm);
        check("single_accept", ga, 1'b1);
        alu_valid = 1'b0;
        cycle(ga, gm);
        check("single_rf_data", rf_model[3], 32'hDEADBEEF);
        cycle(ga, gm);

        // Hazard query for a queued register, then for one never queued.
        for (int q = 0; q < 2; q++) begin
            query_addr = (q == 0) ? 5'd9 : 5'd5;
            alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h7;
            cycle(ga, gm);
            alu_addr = 5'd9; alu_data = 32'h9;
            cycle(ga, gm);
            alu_valid = 1'b0;
            cycle(ga, gm);
            cycle(ga, gm);
        end
        query_addr = 5'd0;

        // Same-register ordering: the later write wins, both issue.
        r4_writes = 0;
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h11;
        cycle(ga, gm);
        alu_valid = 1'b0; mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h22;
        cycle(ga, gm);
        mem_valid = 1'b0;
        cycle(ga, gm);
        cycle(ga, gm);
        check("r4_final", rf_model[4], 32'h22);
        check("r4_write_count", r4_writes, 2);

        // Reset mid-operation with an entry queued.
        query_addr = 5'd10;
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA;
        cycle(ga, gm);
        alu_valid = 1'b1; mem_valid = 1'b1; alu_addr = 5'd11; mem_addr = 5'd12;
        #2 rst = 1'b0;
        #1;
        check("midrst_rf_en", rf_en, 0);
        check("midrst_count", count, 0);
        check("midrst_query_hit", query_hit, 0);
        check("midrst_alu_ready", alu_ready, 0);
        check("midrst_mem_ready", mem_ready, 0);
        sb.delete();
        m_last_mem = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        query_addr = 5'd0;
        cycle(ga, gm);
        check("post_rst_first_grant_alu", {ga, gm}, 2'b10);

        // Contention: grants alternate starting with MEM (ALU just won).
        grant_log.delete();
        run(12, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            check("contention_order", grant_log[k], (k % 2) == 0);
        end

        // Sustained traffic across many pointer wraps, then load-only traffic.
        run(100, 1'b1, 1'b1);
        run(20, 1'b0, 1'b1);
        cycle(ga, gm);
        check("final_empty", count, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end for the CPU register file. It accepts results from two producers, the ALU and the load unit, using valid/ready handshakes. It buffers them in a small in-order queue and drives the register file's single write port (`en`, `addr_in`, `data_in`) with at most one write per cycle. It also exposes a pending-write query so operand fetch can stall on a register that is still queued.

## Interface
Parameters:
- `WORD`, default `constants::WORD_LENGTH`: data width.
- `ADDR`, default `macros::log_2(constants::WORD_LENGTH)`: register address width. Must match the register file's address ports.
- `DEPTH`, default 4: queue entries. Must be a power of two and ≥2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `alu_valid`  in  1  ALU result offered.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_addr`  in  ADDR  ALU destination register.
- `alu_data`  in  WORD  ALU result.
- `mem_valid`  in  1  load result offered.
- `mem_ready`  out  1  load result accepted this cycle.
- `mem_addr`  in  ADDR  load destination register.
- `mem_data`  in  WORD  load result.
- `rf_en`  out  1  write strobe to the register file `en`.
- `rf_addr`  out  ADDR  to the register file `addr_in`.
- `rf_data`  out  WORD  to the register file `data_in`.
- `query_addr`  in  ADDR  register being read by operand fetch.
- `query_hit`  out  1  a queued entry targets `query_addr`.
- `count`  out  clog2(DEPTH)+1  entries currently queued.

## Operation
- **State:** a circular queue of DEPTH entries `{addr, data}`, a head pointer, a tail pointer, `count`, and a round-robin flag `last_mem`.
- **Space:** `space = (count < DEPTH)`. The queue accepts at most one producer per cycle.
- **Arbitration** (combinational; `space` must be 1 for any grant):
  - Only one producer valid: grant that producer.
  - Both valid: grant MEM if `last_mem == 0`, otherwise grant ALU.
  - Grant ready is asserted only to the winner. The loser's ready is 0.
  - A producer's ready never depends on its own valid.
- **Handshake:** a transfer occurs when `x_valid && x_ready` at a rising edge.
  - Producers must hold valid, addr and data stable until the transfer.
  - The block never accepts without valid.
- **Push:** on a transfer, write the granted `{addr, data}` at the tail, then `tail <= tail+1` (mod DEPTH). Set `last_mem <= 1` if MEM was granted, `0` if ALU was granted. `last_mem` is unchanged when there is no transfer.
- **Drain** (combinational from head):
  - `rf_en = (count != 0)`, `rf_addr = head.addr`, `rf_data = head.data`.
  - Every edge with `count != 0` pops: `head <= head+1` (mod DEPTH). The register file captures the entry on that same edge.
- **Count update:**
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - Neither: unchanged.
- **Full:** with `count == DEPTH`, both readies are 0 even though a pop occurs that cycle. There is no same-cycle refill when full.
- **Ordering:** writes reach the register file strictly in acceptance order. Two queued writes to the same register both issue, and the later one wins.
- **`query_hit`:** OR over all occupied entries of `(entry.addr == query_addr)`.
  - It ignores the entry being offered but not yet accepted.
  - It includes the head entry even in the cycle it is being written.
- **Reset** (any time, including mid-drain): queue contents are discarded, with no write issued for pending entries.

## Timing
- **Reset values** (asserted asynchronously while `rst == 0`):
  - `count = 0`, head = tail = 0, `last_mem = 1` (ALU favoured first).
  - `rf_en = 0`, `query_hit = 0`.
  - `alu_ready = mem_ready = 0`.
  - `rf_addr`/`rf_data` = 0.
- **First edge after reset release:** readies follow the arbitration rules combinationally.
- **Latency:**
  - Result accepted at edge N.
  - With an empty queue, `rf_en` is high during cycle N→N+1.
  - The register file is written at edge N+1.
- **Throughput:** sustained one accept and one register-file write per cycle once non-empty.
- **Combinational paths:** `alu_ready`/`mem_ready` depend on `alu_valid`, `mem_valid`, `count` and `last_mem`. There is no path from `rf_*` back to the readies.
- **Wrap-around:** the pointers wrap modulo DEPTH with no bubble. `count` alone distinguishes full from empty.

## Test plan
- **Reset then single write:** release `rst`, ALU offers `addr=3`, `data=0xDEADBEEF` for one cycle.
  - `alu_ready=1`, then `rf_en=1`, `rf_addr=3`, `rf_data=0xDEADBEEF` for exactly one cycle.
  - `count` goes 0→1→0.
- **Contention:** both producers valid every cycle with distinct addresses 1, 2, … Grants alternate ALU, MEM, ALU, MEM starting with ALU, and `rf_addr` follows acceptance order.
- **Full/back-pressure:** hold the queue draining while offering every cycle.
  - `count` never exceeds DEPTH.
  - Force `count == DEPTH` by asserting `rst`-free stall injection via the bench model: the readies must be 0 that cycle, and no entry is lost or duplicated across 20 pointer wraps.
- **Hazard query:** queue `addr=7` then `addr=9`, and set `query_addr=9`.
  - `query_hit=1` until the `addr=9` write edge, then 0.
  - With `query_addr=5`, `query_hit=0` throughout.
- **Same-register ordering:** ALU writes `r4=0x11`, then MEM writes `r4=0x22`. The register file ends with `r4=0x22`, and exactly two writes are observed.
- **Reset mid-operation:** assert `rst` low asynchronously with 3 entries queued.
  - `rf_en` drops immediately and `count=0`.
  - After release, no stale write appears, and the next ALU result is granted first.
